product_accumulator: RTL
========================

# product_accumulator

Streaming accumulator directly downstream of the parameterised `Multiplier`. It consumes the 2N-bit `Product` values, one per handshake beat, and sums them into a wider accumulator. When the beat flagged `in_last` is accepted, it presents the batch sum, term count and overflow flag on an output handshake. Typical use: dot products and MAC reductions over the combinational multiplier.

## Interface
- `N`, default 5: operand width of the upstream multiplier; product width is 2N.
- `ACC_W`, default 16: accumulator width; must be ≥ 2N.
- `CNT_W`, default 4: width of the term counter.

Ports:
- `clk`, input, 1: single clock, rising edge.
- `rst`, input, 1: synchronous, active-high reset.
- `in_valid`, input, 1: product beat valid.
- `in_ready`, output, 1: block can accept a beat.
- `product`, input, 2N: unsigned product from the multiplier.
- `in_last`, input, 1: beat is the final term of the batch.
- `out_valid`, output, 1: batch result valid.
- `out_ready`, input, 1: consumer accepts the result.
- `acc_out`, output, ACC_W: batch sum.
- `term_count`, output, CNT_W: number of beats in the batch; saturates at all-ones.
- `overflow`, output, 1: sticky; some addition in the batch exceeded 2^ACC_W−1.

## Operation
- **Beat transfer:** occurs when `in_valid && in_ready` at a rising edge. The product is zero-extended to ACC_W and added to the accumulator.
- **States:**
  - `IDLE`: accumulator 0, count 0, `in_ready`=1.
  - `ACCUM`: ≥1 beat taken, `in_ready`=1.
  - `HOLD`: result presented, `in_ready`=0, `out_valid`=1.
- **Transitions:**
  - `IDLE`→`ACCUM` on a beat without `in_last`.
  - `IDLE`/`ACCUM`→`HOLD` on a beat with `in_last`; that beat is included in the sum.
  - `ACCUM` holds on no beat.
  - `HOLD`→`IDLE` when `out_ready`=1; accumulator, count and overflow clear on that edge.
- **Overflow:** the carry out of the ACC_W add sets `overflow`; it stays set until the batch is consumed. Overflow behaviour is set by `ACC_SATURATE_EN`.
- **Term count:** increments per beat and clamps at 2^CNT_W−1.
- **Output stability:** `acc_out`, `term_count` and `overflow` are registered and stable throughout `HOLD`.
- **Simultaneous events:** `out_ready` high outside `HOLD` is ignored. No beat is accepted in the cycle `HOLD` exits; `in_ready` returns 1 on the following cycle.
- **Reset:** reset mid-batch discards the partial sum and forces `IDLE`.

## Timing
- **Reset values:** `in_ready`=1, `out_valid`=0, `acc_out`=0, `term_count`=0, `overflow`=0, state `IDLE`.
- **Accumulate throughput:** 1 beat per cycle while accumulating.
- **Result latency:** `out_valid` asserts on the edge that accepts the `in_last` beat, i.e. visible 1 cycle after that beat is presented.
- **Back-pressure:** `out_valid` remains high indefinitely until `out_ready`. `in_ready` stays 0 for the whole of `HOLD`.
- **Minimum batch:** 1 beat (`in_last` on the first beat). Batch period is then 2 cycles with `out_ready` tied high.

## Configuration
- **`ACC_SATURATE_EN` defined:** on overflow the accumulator clamps to 2^ACC_W−1 and holds there for the rest of the batch. `overflow` is set.
- **`ACC_SATURATE_EN` undefined:** the accumulator wraps modulo 2^ACC_W. `overflow` is set identically.

## Structure
- **Shared package `accum_pkg`:**
  - state enum typedef (`IDLE`, `ACCUM`, `HOLD`)
  - localparam defaults for N, ACC_W, CNT_W
  - the `ACC_W ≥ 2N` check constant
- **Sub-module `acc_adder`:** combinational ACC_W adder producing next sum plus carry, with the `ACC_SATURATE_EN` clamp inside. The FSM and registers live in the top module.

## Test plan
- **Basic sum:** N=5, ACC_W=16. Products 15, 225, 18, 256, 96, with `in_last` on 96 and `out_ready`=1 → `acc_out`=610, `term_count`=5, `overflow`=0, `out_valid` for 1 cycle.
- **Single-beat batch:** product 256 with `in_last` → next cycle `acc_out`=256, `term_count`=1; `in_ready` low 1 cycle, then high.
- **Back-pressure:** hold `out_ready`=0 for 3 cycles after a result while driving `in_valid`=1 → `out_valid` held 3+ cycles, `acc_out` constant, `in_ready`=0, no beat consumed; release → `IDLE`, next batch sum starts from 0.
- **Overflow:** ACC_W=10, five beats of 225 (sum 1125) → `overflow`=1. Result is `acc_out`=101 without the macro and 1023 with `ACC_SATURATE_EN`.
- **Reset mid-batch:** 2 beats (225, 18), then `rst` for 1 cycle, then 15 with `in_last` → `acc_out`=15, `term_count`=1. All outputs at reset values during reset.
- **Count saturation:** CNT_W=4, 20 beats of product 1 → `term_count`=15, `acc_out`=20.

Source files
------------

// File: rtl/accum_pkg.sv
// ============================================================================
// Module : accum_pkg
// Brief  : Shared types and defaults for the product accumulator.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package accum_pkg;

  localparam int unsigned DEF_N     = 5;
  localparam int unsigned DEF_ACC_W = 16;
  localparam int unsigned DEF_CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_e;

  // The accumulator must be wide enough to hold a single full product.
  function automatic bit acc_width_ok(input int unsigned n, input int unsigned acc_w);
    return acc_w >= 2 * n;
  endfunction

  localparam bit DEF_WIDTH_OK = acc_width_ok(DEF_N, DEF_ACC_W);

endpackage

`default_nettype wire

// File: rtl/acc_adder.sv
// ============================================================================
// Module : acc_adder
// Brief  : ACC_W adder returning next sum and carry; clamps when ACC_SATURATE_EN.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module acc_adder
  import accum_pkg::*;
#(
  parameter int unsigned ACC_W = DEF_ACC_W
) (
  input  logic [ACC_W-1:0] i_acc,
  input  logic [ACC_W-1:0] i_addend,
  output logic [ACC_W-1:0] o_sum,
  output logic             o_carry
);

  logic [ACC_W:0] raw_sum;

  always_comb begin
    raw_sum = {1'b0, i_acc} + {1'b0, i_addend};
    o_carry = raw_sum[ACC_W];
`ifdef ACC_SATURATE_EN
    // Once at full scale any further non-zero add carries again, so it sticks.
    o_sum   = o_carry ? {ACC_W{1'b1}} : raw_sum[ACC_W-1:0];
`else
    o_sum   = raw_sum[ACC_W-1:0];
`endif
  end

endmodule

`default_nettype wire

// File: rtl/product_accumulator.sv
// ============================================================================
// Module : product_accumulator
// Brief  : Streams multiplier products into a batch sum with count/overflow.
//          Optional macro ACC_SATURATE_EN selects clamping instead of wrap.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module product_accumulator
  import accum_pkg::*;
#(
  parameter int unsigned N     = DEF_N,
  parameter int unsigned ACC_W = DEF_ACC_W,
  parameter int unsigned CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2*N-1:0]   product,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] acc_out,
  output logic [CNT_W-1:0] term_count,
  output logic             overflow
);

  if (!acc_width_ok(N, ACC_W)) begin : g_width_check
    $error("product_accumulator: ACC_W must be at least 2*N");
  end

  state_e           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;

  logic [ACC_W-1:0] sum;
  logic             carry;
  logic             beat;

  acc_adder #(
    .ACC_W (ACC_W)
  ) u_adder (
    .i_acc    (acc_q),
    .i_addend (ACC_W'(product)),
    .o_sum    (sum),
    .o_carry  (carry)
  );

  assign beat = in_valid && (state_q != HOLD);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      IDLE, ACCUM: begin
        if (beat) begin
          acc_d   = sum;
          cnt_d   = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);
          ovf_d   = ovf_q | carry;
          state_d = in_last ? HOLD : ACCUM;
        end
      end
      HOLD: begin
        // Clearing on the consume edge lets IDLE start the next batch from zero.
        if (out_ready) begin
          acc_d   = '0;
          cnt_d   = '0;
          ovf_d   = 1'b0;
          state_d = IDLE;
        end
      end
      default: begin
        acc_d   = '0;
        cnt_d   = '0;
        ovf_d   = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    in_ready   = (state_q != HOLD);
    out_valid  = (state_q == HOLD);
    acc_out    = acc_q;
    term_count = cnt_q;
    overflow   = ovf_q;
  end

endmodule

`default_nettype wire
